// File: rtl/fic_clk_pkg.sv
// Shared definitions for the clock/reset sequencer: state encoding,
// status field widths and the saturating event-counter helper.
package fic_clk_pkg;

  localparam int STATE_W = 3;
  localparam int LLC_W   = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_WAIT_MSS   = 3'd2,
    ST_REL_FABRIC = 3'd3,
    ST_RUN        = 3'd4,
    ST_LOCK_LOST  = 3'd5
  } state_t;

  // Increment that sticks at all-ones so the status register never wraps.
  function automatic logic [LLC_W-1:0] sat_inc(input logic [LLC_W-1:0] v);
    return (v == '1) ? v : v + LLC_W'(1);
  endfunction

endpackage

// File: rtl/fic_sync2.sv
// Two-flop synchroniser with asynchronous active-low reset to a
// selectable value. Used for the reset release and the async status inputs.
module fic_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input into the i_clk domain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/fic_clk_reset_seq.sv
// Clock/reset sequencer: qualifies CCC lock and MSS ready, then releases
// the fabric reset followed by the FIC reset after a fixed delay. Lock loss
// or a soft request re-runs the sequence; status goes to the FIC registers.
module fic_clk_reset_seq
  import fic_clk_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int MSS_TIMEOUT_CYCLES = 50000,
  parameter int FIC_DELAY_CYCLES   = 16,
  parameter int CNT_W              = 16
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               CCC_LOCK,
  input  logic               MSS_READY,
  input  logic               SOFT_RESET,
  output logic               FABRIC_RESET_N,
  output logic               FIC_RESET_N,
  output logic               TIMEOUT,
  output logic [STATE_W-1:0] STATE,
  output logic [LLC_W-1:0]   LOCK_LOSS_CNT
);

  localparam logic [CNT_W-1:0] LOCK_LD = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MSS_LD  = CNT_W'(MSS_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] FIC_LD  = CNT_W'(FIC_DELAY_CYCLES - 1);

  logic w_rst_n;
  logic w_lock_s;
  logic w_ready_s;
  logic w_cnt_zero;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fab_n;
  logic             r_fic_n;
  logic             r_timeout;
  logic [LLC_W-1:0] r_llc;

  // Reset asserts asynchronously through the synchroniser's own reset,
  // but its release reaches the FSM two clock edges later.
  fic_sync2 #(.RST_VAL(1'b0)) u_rst_sync (
    .i_clk   (CLK),
    .i_rst_n (RESET_N),
    .i_d     (1'b1),
    .o_q     (w_rst_n)
  );

  fic_sync2 #(.RST_VAL(1'b0)) u_lock_sync (
    .i_clk   (CLK),
    .i_rst_n (RESET_N),
    .i_d     (CCC_LOCK),
    .o_q     (w_lock_s)
  );

  fic_sync2 #(.RST_VAL(1'b0)) u_ready_sync (
    .i_clk   (CLK),
    .i_rst_n (RESET_N),
    .i_d     (MSS_READY),
    .o_q     (w_ready_s)
  );

  assign w_cnt_zero = (r_cnt == '0);

  // Sequencer FSM with the shared down-counter and registered outputs.
  always_ff @(posedge CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_fab_n   <= 1'b0;
      r_fic_n   <= 1'b0;
      r_timeout <= 1'b0;
      r_llc     <= '0;
    end else if (SOFT_RESET && (r_state != ST_IDLE)) begin
      // Soft request outranks lock loss and is not counted as one.
      r_state   <= ST_IDLE;
      r_fab_n   <= 1'b0;
      r_fic_n   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_WAIT_LOCK;
          r_cnt   <= LOCK_LD;
          r_fab_n <= 1'b0;
          r_fic_n <= 1'b0;
        end
        ST_WAIT_LOCK: begin
          if (!w_lock_s) begin
            r_cnt <= LOCK_LD;
          end else if (w_cnt_zero) begin
            r_state <= ST_WAIT_MSS;
            r_cnt   <= MSS_LD;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_WAIT_MSS: begin
          if (!w_lock_s) begin
            r_state <= ST_LOCK_LOST;
            r_fab_n <= 1'b0;
            r_fic_n <= 1'b0;
            r_llc   <= sat_inc(r_llc);
          end else if (w_ready_s) begin
            r_state <= ST_REL_FABRIC;
            r_cnt   <= FIC_LD;
            r_fab_n <= 1'b1;
          end else if (w_cnt_zero) begin
            // Timed out: flag it, hold the counter, keep honouring ready.
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_REL_FABRIC: begin
          if (!w_lock_s) begin
            r_state <= ST_LOCK_LOST;
            r_fab_n <= 1'b0;
            r_fic_n <= 1'b0;
            r_llc   <= sat_inc(r_llc);
          end else if (w_cnt_zero) begin
            r_state <= ST_RUN;
            r_fic_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!w_lock_s) begin
            r_state <= ST_LOCK_LOST;
            r_fab_n <= 1'b0;
            r_fic_n <= 1'b0;
            r_llc   <= sat_inc(r_llc);
          end
        end
        ST_LOCK_LOST: begin
          r_state <= ST_WAIT_LOCK;
          r_cnt   <= LOCK_LD;
        end
        default: begin
          r_state <= ST_IDLE;
          r_fab_n <= 1'b0;
          r_fic_n <= 1'b0;
        end
      endcase
    end
  end

  assign FABRIC_RESET_N = r_fab_n;
  assign FIC_RESET_N    = r_fic_n;
  assign TIMEOUT        = r_timeout;
  assign STATE          = r_state;
  assign LOCK_LOSS_CNT  = r_llc;

endmodule

// File: tb/tb_fic_clk_reset_seq.sv
// Scoreboard bench for the clock/reset sequencer. Each expected output
// change (state/resets/flag/count plus the number of falling clock edges
// since the previous change) is queued when stimulus is issued; a monitor
// pops and compares whenever the observed outputs change.
module tb_fic_clk_reset_seq;

  logic       CLK;
  logic       RESET_N;
  logic       CCC_LOCK;
  logic       MSS_READY;
  logic       SOFT_RESET;
  logic       FABRIC_RESET_N;
  logic       FIC_RESET_N;
  logic       TIMEOUT;
  logic [2:0] STATE;
  logic [7:0] LOCK_LOSS_CNT;

  typedef struct packed {
    logic [2:0] st;
    logic       fab;
    logic       fic;
    logic       to;
    logic [7:0] llc;
  } snap_t;

  typedef struct {
    snap_t s;
    int    dt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  fic_clk_reset_seq #(
    .LOCK_STABLE_CYCLES (8),
    .MSS_TIMEOUT_CYCLES (20),
    .FIC_DELAY_CYCLES   (4),
    .CNT_W              (16)
  ) dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .CCC_LOCK       (CCC_LOCK),
    .MSS_READY      (MSS_READY),
    .SOFT_RESET     (SOFT_RESET),
    .FABRIC_RESET_N (FABRIC_RESET_N),
    .FIC_RESET_N    (FIC_RESET_N),
    .TIMEOUT        (TIMEOUT),
    .STATE          (STATE),
    .LOCK_LOSS_CNT  (LOCK_LOSS_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // dt = 0 means the spacing from the previous change is not checked.
  task automatic push(input int st, input int fab, input int fic,
                      input int to, input int llc, input int dt);
    exp_t e;
    e.s.st  = 3'(st);
    e.s.fab = 1'(fab);
    e.s.fic = 1'(fic);
    e.s.to  = 1'(to);
    e.s.llc = 8'(llc);
    e.dt    = dt;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Monitor: compare every observed output change against the queue head.
  initial begin
    snap_t cur;
    snap_t prev;
    exp_t  e;
    bit    have_prev;
    int    cyc;
    int    last;
    have_prev = 1'b0;
    prev      = '0;
    cyc       = 0;
    last      = 0;
    forever begin
      @(negedge CLK);
      cyc++;
      cur = {STATE, FABRIC_RESET_N, FIC_RESET_N, TIMEOUT, LOCK_LOSS_CNT};
      if (!have_prev || cur != prev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_change cyc=%0d: got st=%0d fab=%0b fic=%0b to=%0b llc=%0d, required no change",
                   cyc, cur.st, cur.fab, cur.fic, cur.to, cur.llc);
        end else begin
          e = exp_q.pop_front();
          if (cur != e.s || (e.dt != 0 && (cyc - last) != e.dt)) begin
            n_errors++;
            $display("FAIL change cyc=%0d: got st=%0d fab=%0b fic=%0b to=%0b llc=%0d dt=%0d, required st=%0d fab=%0b fic=%0b to=%0b llc=%0d dt=%0d",
                     cyc, cur.st, cur.fab, cur.fic, cur.to, cur.llc, cyc - last,
                     e.s.st, e.s.fab, e.s.fic, e.s.to, e.s.llc, e.dt);
          end
        end
        prev      = cur;
        have_prev = 1'b1;
        last      = cyc;
      end
    end
  end

  // Stimulus: cycle numbers in comments count falling edges from time 0.
  initial begin
    snap_t now_s;
    int    llc;
    CCC_LOCK   = 1'b0;
    MSS_READY  = 1'b0;
    SOFT_RESET = 1'b0;
    RESET_N    = 1'b1;
    push(0, 0, 0, 0, 0, 0);            // reset state seen at edge 1
    #1 RESET_N = 1'b0;
    step(3);                           // edge 3: release reset

    // Nominal bring-up
    RESET_N = 1'b1;
    push(1, 0, 0, 0, 0, 5);            // WAIT_LOCK at 6
    step(5);                           // edge 8
    CCC_LOCK = 1'b1;
    push(2, 0, 0, 0, 0, 12);           // WAIT_MSS at 18
    step(25);                          // edge 33
    MSS_READY = 1'b1;
    push(3, 1, 0, 0, 0, 18);           // REL_FABRIC at 36
    push(4, 1, 1, 0, 0, 4);            // RUN at 40
    step(12);                          // edge 45

    // Soft reset back to qualification with lock and ready removed
    SOFT_RESET = 1'b1;
    CCC_LOCK   = 1'b0;
    MSS_READY  = 1'b0;
    push(0, 0, 0, 0, 0, 6);            // IDLE at 46
    push(1, 0, 0, 0, 0, 1);            // WAIT_LOCK at 47
    step(1);
    SOFT_RESET = 1'b0;

    // Lock glitch during qualification restarts the stability count
    step(4);                           // edge 50
    CCC_LOCK = 1'b1;
    step(5);                           // edge 55
    CCC_LOCK = 1'b0;
    step(1);                           // edge 56
    CCC_LOCK = 1'b1;
    push(2, 0, 0, 0, 0, 19);           // WAIT_MSS at 66

    // MSS timeout, then late ready still releases
    push(2, 0, 0, 1, 0, 20);           // TIMEOUT at 86
    step(34);                          // edge 90
    MSS_READY = 1'b1;
    push(3, 1, 0, 1, 0, 7);            // REL_FABRIC at 93
    push(4, 1, 1, 1, 0, 4);            // RUN at 97
    step(10);                          // edge 100

    // Repeated lock loss in RUN, count saturates at 255
    for (int i = 1; i <= 300; i++) begin
      llc = (i > 255) ? 255 : i;
      CCC_LOCK = 1'b0;
      push(5, 0, 0, 1, llc, 6);
      push(1, 0, 0, 1, llc, 1);
      push(2, 0, 0, 1, llc, 11);
      push(3, 1, 0, 1, llc, 1);
      push(4, 1, 1, 1, llc, 4);
      step(5);
      CCC_LOCK = 1'b1;
      step(18);
    end                                // edge 7000, in RUN since 6997

    // Soft reset coincident with lock-loss detection
    CCC_LOCK = 1'b0;
    step(2);                           // edge 7002
    SOFT_RESET = 1'b1;
    push(0, 0, 0, 0, 255, 6);          // IDLE at 7003, TIMEOUT cleared
    push(1, 0, 0, 0, 255, 1);          // WAIT_LOCK at 7004
    step(1);
    SOFT_RESET = 1'b0;
    step(2);                           // edge 7005
    CCC_LOCK = 1'b1;
    push(2, 0, 0, 0, 255, 11);         // WAIT_MSS at 7015
    push(3, 1, 0, 0, 255, 1);          // REL_FABRIC at 7016
    step(12);                          // edge 7017

    // Asynchronous reset in REL_FABRIC, checked before any clock edge
    push(0, 0, 0, 0, 0, 2);
    #2 RESET_N = 1'b0;
    #1;
    now_s = {STATE, FABRIC_RESET_N, FIC_RESET_N, TIMEOUT, LOCK_LOSS_CNT};
    n_checks++;
    if (now_s != '0) begin
      n_errors++;
      $display("FAIL async_reset: got st=%0d fab=%0b fic=%0b to=%0b llc=%0d, required all zero",
               now_s.st, now_s.fab, now_s.fic, now_s.to, now_s.llc);
    end
    step(3);                           // edge 7020
    RESET_N = 1'b1;
    push(1, 0, 0, 0, 0, 5);            // WAIT_LOCK at 7023
    push(2, 0, 0, 0, 0, 8);            // WAIT_MSS at 7031
    push(3, 1, 0, 0, 0, 1);            // REL_FABRIC at 7032
    push(4, 1, 1, 0, 0, 4);            // RUN at 7036
    step(20);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL pending_expectations: got %0d outstanding, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
